// File: rtl/mac_lane_array.sv
// N independent unsigned multiply-accumulate lanes, out = a*b + c, with a fixed two-stage pipeline.
// Every edge advances the pipeline; there is no handshake or stall.
module mac_lane_array #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N-1:0][WIDTH-1:0]     a,
  input  logic [N-1:0][WIDTH-1:0]     b,
  input  logic [N-1:0][2*WIDTH-1:0]   c,
  output logic [N-1:0][2*WIDTH-1:0]   out
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [WIDTH-1:0]   a_q;
      logic [WIDTH-1:0]   b_q;
      logic [2*WIDTH-1:0] c_q;
      logic [2*WIDTH-1:0] prod;
      logic [2*WIDTH-1:0] out_d;
      logic [2*WIDTH-1:0] out_q;

      // Zero-extend so the product is the full 2*WIDTH bits; the sum carry-out is dropped.
      always_comb begin
        prod  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        out_d = prod + c_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= '0;
          out_q <= '0;
        end else begin
          a_q   <= a[gi];
          b_q   <= b[gi];
          c_q   <= c[gi];
          out_q <= out_d;
        end
      end

      assign out[gi] = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_mac_lane_array.sv
// Scoreboard bench for mac_lane_array: expected lane results are queued when inputs are driven
// and compared two edges later; reset behaviour and arithmetic extremes are checked directly.
module tb_mac_lane_array;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int W2    = 2 * WIDTH;

  typedef logic [N-1:0][WIDTH-1:0] ab_t;
  typedef logic [N-1:0][W2-1:0]    cw_t;

  logic clk = 1'b0;
  logic rst_n;
  ab_t  a, b;
  cw_t  c, out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  cw_t exp_q[$];

  mac_lane_array #(.WIDTH(WIDTH), .N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .out  (out)
  );

  always #5 clk = ~clk;

  function automatic cw_t model(input ab_t ma, input ab_t mb, input cw_t mc);
    cw_t r;
    for (int i = 0; i < N; i++) begin
      logic [31:0] full;
      full = 32'(ma[i]) * 32'(mb[i]) + 32'(mc[i]);
      r[i] = full[W2-1:0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input cw_t obs, input cw_t expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Called at a negedge: drive one operand set, let one edge pass, compare at the next negedge.
  task automatic cycle(input string tag, input ab_t na, input ab_t nb, input cw_t nc);
    a = na; b = nb; c = nc;
    exp_q.push_back(model(na, nb, nc));
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      cw_t e;
      e = exp_q.pop_front();
      $display("txn %s out=%h expected=%h", tag, out, e);
      check(tag, out, e);
    end else begin
      $display("txn %s (fill) out=%h expected=0", tag, out);
      check({tag, "_fill"}, out, '0);
    end
  endtask

  function automatic ab_t rand_ab();
    ab_t r;
    for (int i = 0; i < N; i++) r[i] = WIDTH'($urandom);
    return r;
  endfunction

  function automatic cw_t rand_c();
    cw_t r;
    for (int i = 0; i < N; i++) r[i] = W2'($urandom);
    return r;
  endfunction

  initial begin
    ab_t ta, tb;
    cw_t tc;

    // Reset held with random inputs
    rst_n = 1'b0;
    a = rand_ab(); b = rand_ab(); c = rand_c();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      $display("txn reset_hold%0d out=%h", k, out);
      check("reset_hold", out, '0);
      a = rand_ab(); b = rand_ab(); c = rand_c();
    end
    rst_n = 1'b1;

    // Latency/basic on lane 0; first call also checks out stays 0 before the first result
    ta = '0; tb = '0; tc = '0;
    ta[0] = 8'd3; tb[0] = 8'd5; tc[0] = 16'd7;
    cycle("basic_fill", ta, tb, tc);
    cycle("basic_3x5p7", '0, '0, '0);

    // Extremes, one per lane, plus the wrap case
    ta = '1; tb = '1;
    tc[0] = 16'h0000; tc[1] = 16'h01FE; tc[2] = 16'h01FF; tc[3] = 16'hFFFF;
    cycle("extremes", ta, tb, tc);
    cycle("extremes2", '0, '0, '1);

    // Lane isolation: a=i+1, b=10, c=i -> {43,32,21,10}
    for (int i = 0; i < N; i++) begin
      ta[i] = WIDTH'(i + 1); tb[i] = 8'd10; tc[i] = W2'(i);
    end
    cycle("isolation", ta, tb, tc);
    cycle("isolation_hold", ta, tb, tc);
    ta[2] = 8'd200; tb[2] = 8'd201; tc[2] = 16'hABCD;
    cycle("vary_lane2", ta, tb, tc);
    cycle("vary_lane2b", ta, tb, tc);
    begin
      cw_t iso;
      iso[0] = 16'd10; iso[1] = 16'd21; iso[2] = 16'(200 * 201 + 16'hABCD); iso[3] = 16'd43;
      check("isolation_const", out, iso);
    end

    // Mid-stream reset: out must clear before the next edge
    cycle("pre_reset", rand_ab(), rand_ab(), rand_c());
    a = rand_ab(); b = rand_ab(); c = rand_c();
    #2 rst_n = 1'b0;
    #1;
    $display("txn midstream_reset out=%h", out);
    check("midstream_reset", out, '0);
    exp_q.delete();
    @(negedge clk);
    check("midstream_reset_hold", out, '0);
    rst_n = 1'b1;

    // Streaming random with sparse c
    for (int k = 0; k < 3000; k++) begin
      tc = ($urandom_range(0, 1) == 1) ? rand_c() : '0;
      cycle($sformatf("stream%0d", k), rand_ab(), rand_ab(), tc);
    end
    cycle("drain", '0, '0, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
